// File: rtl/i2c_tx_engine.sv
// Slave-side I2C transmit engine: serialises a byte MSB-first on SCL falling
// edges, releases SDA for the master ACK/NACK and samples it, and drives the
// slave ACK bit when the receive path asks for one.
module i2c_tx_engine #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  scl_rise,
  input  logic                  scl_fall,
  input  logic                  start_found,
  input  logic                  stop_found,
  input  logic                  sda_in,
  input  logic                  tx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_ready,
  input  logic                  send_ack,
  output logic [1:0]            sda_mode,
  output logic                  tx_out,
  output logic                  ack_valid,
  output logic                  ack_nack,
  output logic                  busy
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH);

  localparam logic [1:0] MODE_IDLE  = 2'b00;
  localparam logic [1:0] MODE_LOW   = 2'b01;
  localparam logic [1:0] MODE_MACK  = 2'b10;
  localparam logic [1:0] MODE_DATA  = 2'b11;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ACK_ARM   = 3'd1,
    ACK_DRIVE = 3'd2,
    LOADED    = 3'd3,
    SHIFT     = 3'd4,
    MACK_WAIT = 3'd5,
    MACK_DONE = 3'd6
  } state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
  logic [CW-1:0]         count, count_nxt;
  logic [1:0]            sda_mode_nxt;
  logic                  tx_out_nxt;
  logic                  ack_valid_nxt;
  logic                  ack_nack_nxt;
  logic                  busy_nxt;

  logic rise;
  logic fall;
  logic abort;

  // Coincident edge pulses are ambiguous and ignored; START/STOP abort.
  assign rise  = scl_rise & ~scl_fall;
  assign fall  = scl_fall & ~scl_rise;
  assign abort = start_found | stop_found;

  // Handshake is offered only in IDLE; a slave ACK request wins, and an abort
  // in the same cycle would discard the byte, so it is not offered then either.
  assign tx_ready = (state == IDLE) & ~send_ack & ~abort;

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      shreg     <= '1;
      count     <= '0;
      sda_mode  <= MODE_IDLE;
      tx_out    <= 1'b1;
      ack_valid <= 1'b0;
      ack_nack  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      shreg     <= shreg_nxt;
      count     <= count_nxt;
      sda_mode  <= sda_mode_nxt;
      tx_out    <= tx_out_nxt;
      ack_valid <= ack_valid_nxt;
      ack_nack  <= ack_nack_nxt;
      busy      <= busy_nxt;
    end
  end

  // Next-state and next-output logic; abort overrides every other event.
  always_comb begin
    state_nxt     = state;
    shreg_nxt     = shreg;
    count_nxt     = count;
    sda_mode_nxt  = sda_mode;
    tx_out_nxt    = tx_out;
    ack_valid_nxt = 1'b0;
    ack_nack_nxt  = ack_nack;

    if (abort) begin
      state_nxt    = IDLE;
      shreg_nxt    = '1;
      count_nxt    = '0;
      sda_mode_nxt = MODE_IDLE;
      tx_out_nxt   = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (send_ack) begin
            state_nxt = ACK_ARM;
          end else if (tx_valid) begin
            shreg_nxt = tx_data;
            state_nxt = LOADED;
          end else begin
            state_nxt = IDLE;
          end
        end
        ACK_ARM: begin
          if (fall) begin
            sda_mode_nxt = MODE_LOW;
            state_nxt    = ACK_DRIVE;
          end else begin
            state_nxt = ACK_ARM;
          end
        end
        ACK_DRIVE: begin
          if (fall) begin
            sda_mode_nxt = MODE_IDLE;
            state_nxt    = IDLE;
          end else begin
            state_nxt = ACK_DRIVE;
          end
        end
        LOADED: begin
          if (fall) begin
            sda_mode_nxt = MODE_DATA;
            tx_out_nxt   = shreg[DATA_WIDTH-1];
            count_nxt    = CW'(1);
            state_nxt    = SHIFT;
          end else begin
            state_nxt = LOADED;
          end
        end
        SHIFT: begin
          if (fall) begin
            if (count < LAST_BIT) begin
              // Fill with 1 so a stale shift register never pulls SDA low.
              shreg_nxt  = {shreg[DATA_WIDTH-2:0], 1'b1};
              tx_out_nxt = shreg[DATA_WIDTH-2];
              count_nxt  = count + CW'(1);
            end else begin
              sda_mode_nxt = MODE_MACK;
              state_nxt    = MACK_WAIT;
            end
          end else begin
            state_nxt = SHIFT;
          end
        end
        MACK_WAIT: begin
          if (rise) begin
            ack_nack_nxt  = sda_in;
            ack_valid_nxt = 1'b1;
            state_nxt     = MACK_DONE;
          end else begin
            state_nxt = MACK_WAIT;
          end
        end
        MACK_DONE: begin
          if (fall) begin
            sda_mode_nxt = MODE_IDLE;
            count_nxt    = '0;
            state_nxt    = IDLE;
          end else begin
            state_nxt = MACK_DONE;
          end
        end
        default: begin
          state_nxt    = IDLE;
          shreg_nxt    = '1;
          count_nxt    = '0;
          sda_mode_nxt = MODE_IDLE;
          tx_out_nxt   = 1'b1;
        end
      endcase
    end

    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_i2c_tx_engine.sv
// Directed plus randomized bench for i2c_tx_engine. Expected values come from
// transaction-level rules: bit i of a byte appears after the (i+1)th SCL fall.
module tb_i2c_tx_engine;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       scl_rise = 1'b0;
  logic       scl_fall = 1'b0;
  logic       start_found = 1'b0;
  logic       stop_found = 1'b0;
  logic       sda_in = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready;
  logic       send_ack = 1'b0;
  logic [1:0] sda_mode;
  logic       tx_out;
  logic       ack_valid;
  logic       ack_nack;
  logic       busy;

  int tests = 0;
  int failed = 0;

  i2c_tx_engine #(.DATA_WIDTH(8)) dut (
    .clk(clk), .n_rst(n_rst), .scl_rise(scl_rise), .scl_fall(scl_fall),
    .start_found(start_found), .stop_found(stop_found), .sda_in(sda_in),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .send_ack(send_ack), .sda_mode(sda_mode), .tx_out(tx_out),
    .ack_valid(ack_valid), .ack_nack(ack_nack), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fall();
    scl_fall = 1'b1; tick(); scl_fall = 1'b0;
  endtask

  task automatic do_rise();
    scl_rise = 1'b1; tick(); scl_rise = 1'b0;
  endtask

  task automatic do_load(input logic [7:0] d);
    tx_valid = 1'b1; tx_data = d;
    #1 check("load_ready", {31'd0, tx_ready}, 32'd1);
    tick();
    tx_valid = 1'b0;
    check("load_busy", {31'd0, busy}, 32'd1);
    check("load_mode", {30'd0, sda_mode}, 32'd0);
  endtask

  // Shift out the first n bits of d (n falls), checking each presented bit.
  task automatic shift_bits(input logic [7:0] d, input int n, input int gap, input int collide_at);
    for (int i = 0; i < n; i++) begin
      do_fall();
      check("bit_mode", {30'd0, sda_mode}, 32'd3);
      check("bit_val", {31'd0, tx_out}, {31'd0, d[7-i]});
      check("bit_noack", {31'd0, ack_valid}, 32'd0);
      repeat (gap) tick();
      if (i == collide_at) begin
        scl_rise = 1'b1; scl_fall = 1'b1; tick(); scl_rise = 1'b0; scl_fall = 1'b0;
        check("coll_val", {31'd0, tx_out}, {31'd0, d[7-i]});
        check("coll_mode", {30'd0, sda_mode}, 32'd3);
      end
      do_rise();
    end
  endtask

  task automatic xfer(input logic [7:0] d, input logic mack, input int gap, input int collide_at);
    do_load(d);
    shift_bits(d, 8, gap, collide_at);
    do_fall();
    check("mack_mode", {30'd0, sda_mode}, 32'd2);
    sda_in = mack;
    do_rise();
    check("ack_valid", {31'd0, ack_valid}, 32'd1);
    check("ack_nack", {31'd0, ack_nack}, {31'd0, mack});
    sda_in = 1'b1;
    tick();
    check("ack_pulse", {31'd0, ack_valid}, 32'd0);
    check("ack_hold", {31'd0, ack_nack}, {31'd0, mack});
    check("mack_busy", {31'd0, busy}, 32'd1);
    do_fall();
    check("end_mode", {30'd0, sda_mode}, 32'd0);
    check("end_busy", {31'd0, busy}, 32'd0);
    check("end_ready", {31'd0, tx_ready}, 32'd1);
  endtask

  initial begin
    logic [7:0] rd;
    logic       rm;

    // Reset state
    repeat (2) tick();
    n_rst = 1'b1;
    tick();
    check("rst_mode", {30'd0, sda_mode}, 32'd0);
    check("rst_txout", {31'd0, tx_out}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ackv", {31'd0, ack_valid}, 32'd0);
    check("rst_nack", {31'd0, ack_nack}, 32'd0);
    check("rst_ready", {31'd0, tx_ready}, 32'd1);

    // Byte transmit with master ACK, then master NACK
    xfer(8'hA5, 1'b0, 0, -1);
    xfer(8'hFF, 1'b1, 1, -1);

    // Reset asserted mid-SHIFT takes effect immediately
    do_load(8'h5A);
    shift_bits(8'h5A, 4, 0, -1);
    #2 n_rst = 1'b0;
    #1;
    check("mrst_mode", {30'd0, sda_mode}, 32'd0);
    check("mrst_txout", {31'd0, tx_out}, 32'd1);
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_ackv", {31'd0, ack_valid}, 32'd0);
    tick();
    n_rst = 1'b1;
    tick();
    check("mrst_ready", {31'd0, tx_ready}, 32'd1);

    // Slave ACK has priority over a pending byte
    tx_valid = 1'b1; tx_data = 8'h3C; send_ack = 1'b1;
    #1 check("sack_ready", {31'd0, tx_ready}, 32'd0);
    tick();
    send_ack = 1'b0; tx_valid = 1'b0;
    check("sack_busy", {31'd0, busy}, 32'd1);
    check("sack_arm", {30'd0, sda_mode}, 32'd0);
    do_fall();
    check("sack_low", {30'd0, sda_mode}, 32'd1);
    do_rise();
    check("sack_hold", {30'd0, sda_mode}, 32'd1);
    do_fall();
    check("sack_rel", {30'd0, sda_mode}, 32'd0);
    check("sack_idle", {31'd0, busy}, 32'd0);
    xfer(8'h3C, 1'b0, 0, -1);

    // STOP after 3 bits of 0xC3 (tx_out low phase)
    do_load(8'hC3);
    shift_bits(8'hC3, 3, 0, -1);
    check("pre_stop_bit", {31'd0, tx_out}, 32'd0);
    stop_found = 1'b1; tick(); stop_found = 1'b0;
    check("stop_mode", {30'd0, sda_mode}, 32'd0);
    check("stop_busy", {31'd0, busy}, 32'd0);
    check("stop_txout", {31'd0, tx_out}, 32'd1);
    check("stop_ackv", {31'd0, ack_valid}, 32'd0);

    // START during MACK_WAIT wins over a coincident SCL rise
    do_load(8'h96);
    shift_bits(8'h96, 8, 0, -1);
    do_fall();
    check("st_mack", {30'd0, sda_mode}, 32'd2);
    sda_in = 1'b0; start_found = 1'b1; scl_rise = 1'b1;
    tick();
    start_found = 1'b0; scl_rise = 1'b0; sda_in = 1'b1;
    check("start_mode", {30'd0, sda_mode}, 32'd0);
    check("start_busy", {31'd0, busy}, 32'd0);
    check("start_ackv", {31'd0, ack_valid}, 32'd0);
    tick();
    check("start_ackv2", {31'd0, ack_valid}, 32'd0);
    xfer(8'h69, 1'b1, 0, -1);

    // Edge collision mid-byte, then randomized transfers
    xfer(8'hB4, 1'b0, 0, 3);
    for (int k = 0; k < 12; k++) begin
      rd = 8'($urandom);
      rm = 1'($urandom_range(0, 1));
      xfer(rd, rm, int'($urandom_range(0, 2)), int'($urandom_range(0, 9)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
